// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage MIPS core. Converts hazard
// conditions into per-stage enable / bubble / flush strobes for the PC, IF_ID,
// ID_EX and EX_MEM registers. It handles these cases:
//   - load-use stalls (1 cycle)
//   - taken-branch flushes (IF_ID flushed, ID_EX bubbled)
//   - multi-cycle EX operations, with a timeout abort
// It also provides run / single-step gating and saturating stall/flush
// statistics.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   run, step         free-run enable / single-cycle advance pulse
//   id_rs, id_rt,
//   id_uses_rt        source operands of the instruction in ID
//   ex_rd,
//   ex_mem_read       destination / load flag of the instruction in EX
//   ex_branch_taken   taken branch or jump resolved in EX
//   ex_mc_start,
//   ex_mc_done        multi-cycle EX operation handshake
//   pipe_en           advance EX_MEM, MEM_WB and register-file write
//   pc_en             PC / cycle-counter update enable
//   if_id_en,
//   if_id_flush       IF_ID load enable / load NOP
//   id_ex_en,
//   id_ex_bubble      ID_EX load enable / load NOP
//   ex_mem_bubble     EX_MEM loads NOP
//   mc_error          sticky multi-cycle timeout flag
//   stall_cnt,
//   flush_cnt         saturating statistics
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MC_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        ex_mc_start,
    input  logic        ex_mc_done,
    output logic        pipe_en,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        mc_error,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_t;

    localparam logic [8:0] MC_LIMIT = 9'(MC_TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] mc_cnt;
    logic [8:0] mc_cnt_inc;
    logic       adv;
    logic       load_use;
    logic       mc_expired;
    logic       set_error;
    logic       flush_evt;

    assign adv        = run | step;
    assign mc_cnt_inc = {1'b0, mc_cnt} + 9'd1;

    // This is the MC_TIMEOUT-th waiting cycle with no completion.
    assign mc_expired = (mc_cnt_inc == MC_LIMIT);

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Mealy strobes: a hazard seen this cycle takes effect this cycle.
    always_comb begin
        state_nxt     = state;
        pipe_en       = 1'b0;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        set_error     = 1'b0;
        flush_evt     = 1'b0;

        if (adv) begin
            case (state)
                ST_MC_WAIT: begin
                    if (ex_mc_done) begin
                        // Result is ready: let everything advance.
                        pipe_en   = 1'b1;
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        state_nxt = ST_RUN;
                    end else if (mc_expired) begin
                        // Abort: discard the op in EX by loading NOPs into
                        // EX_MEM and ID_EX. The front end stays frozen, so the
                        // instruction in IF_ID is reissued.
                        pipe_en       = 1'b1;
                        id_ex_en      = 1'b1;
                        id_ex_bubble  = 1'b1;
                        ex_mem_bubble = 1'b1;
                        set_error     = 1'b1;
                        state_nxt     = ST_RUN;
                    end else begin
                        pipe_en       = 1'b1;
                        ex_mem_bubble = 1'b1;
                    end
                end
                default: begin
                    if (ex_mc_start && !ex_mc_done) begin
                        pipe_en       = 1'b1;
                        ex_mem_bubble = 1'b1;
                        state_nxt     = ST_MC_WAIT;
                    end else if (ex_branch_taken) begin
                        // The ID instruction is squashed, so any load-use
                        // hazard against it is irrelevant.
                        pipe_en      = 1'b1;
                        pc_en        = 1'b1;
                        if_id_en     = 1'b1;
                        id_ex_en     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        flush_evt    = 1'b1;
                    end else if (load_use) begin
                        pipe_en      = 1'b1;
                        id_ex_en     = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else begin
                        pipe_en  = 1'b1;
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                        id_ex_en = 1'b1;
                    end
                end
            endcase
        end
    end

    // Wait-cycle counter: restarts whenever the FSM is not staying in
    // MC_WAIT, and freezes while the pipeline is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            mc_cnt <= 8'd0;
        end else if (adv) begin
            if (state == ST_MC_WAIT && state_nxt == ST_MC_WAIT) begin
                mc_cnt <= mc_cnt + 8'd1;
            end else begin
                mc_cnt <= 8'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mc_error  <= 1'b0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (set_error) begin
                mc_error <= 1'b1;
            end
            if (adv && !pc_en && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_evt && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        ex_mc_start;
    logic        ex_mc_done;
    logic        pipe_en;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_en;
    logic        id_ex_bubble;
    logic        ex_mem_bubble;
    logic        mc_error;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Strobe vector: {pipe_en, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble}
    logic [6:0] strb;
    assign strb = {pipe_en, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble};

    localparam logic [6:0] S_IDLE = 7'b1111_000;
    localparam logic [6:0] S_LU   = 7'b1001_010;
    localparam logic [6:0] S_BR   = 7'b1111_110;
    localparam logic [6:0] S_MC   = 7'b1000_001;
    localparam logic [6:0] S_TO   = 7'b1001_011;
    localparam logic [6:0] S_NONE = 7'b0000_000;

    hazard_ctrl #(.MC_TIMEOUT(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .run             (run),
        .step            (step),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_start     (ex_mc_start),
        .ex_mc_done      (ex_mc_done),
        .pipe_en         (pipe_en),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_bubble   (ex_mem_bubble),
        .mc_error        (mc_error),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge; return 1 time unit after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        step            = 1'b0;
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_uses_rt      = 1'b0;
        ex_rd           = 5'd0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        ex_mc_start     = 1'b0;
        ex_mc_done      = 1'b0;
    endtask

    initial begin
        int pipe_hi;
        int pc_hi;

        reset = 1'b1;
        run   = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("rst_strobes", 32'(strb), 32'(S_IDLE));
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_flush", 32'(flush_cnt), 32'd0);
        check("rst_mcerr", 32'(mc_error), 32'd0);

        // Load-use on rs
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        #1 check("lu_rs", 32'(strb), 32'(S_LU));
        cyc();
        clear_inputs();
        #1 check("lu_after", 32'(strb), 32'(S_IDLE));
        check("lu_stall", 32'(stall_cnt), 32'd1);

        // ex_rd = 0 never stalls
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        #1 check("lu_r0", 32'(strb), 32'(S_IDLE));
        cyc();
        check("lu_r0_stall", 32'(stall_cnt), 32'd1);

        // rt match only counts when rt is used
        ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd1; id_uses_rt = 1'b0;
        #1 check("lu_rt_unused", 32'(strb), 32'(S_IDLE));
        id_uses_rt = 1'b1;
        #1 check("lu_rt_used", 32'(strb), 32'(S_LU));
        cyc();
        clear_inputs();
        #1 check("lu_rt_stall", 32'(stall_cnt), 32'd2);

        // Branch together with a load-use hazard
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
        #1 check("br_lu", 32'(strb), 32'(S_BR));
        cyc();
        clear_inputs();
        #1 check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd2);

        // Multi-cycle op: done 4 cycles after start
        ex_mc_start = 1'b1;
        #1 check("mc_start", 32'(strb), 32'(S_MC));
        cyc();
        ex_mc_start = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1 check($sformatf("mc_wait%0d", i), 32'(strb), 32'(S_MC));
            cyc();
        end
        ex_mc_done = 1'b1;
        #1 check("mc_done", 32'(strb), 32'(S_IDLE));
        cyc();
        ex_mc_done = 1'b0;
        #1 check("mc_after", 32'(strb), 32'(S_IDLE));
        check("mc_stall", 32'(stall_cnt), 32'd6);

        // start + done together is a single-cycle op
        ex_mc_start = 1'b1; ex_mc_done = 1'b1;
        #1 check("mc_same", 32'(strb), 32'(S_IDLE));
        cyc();
        clear_inputs();
        #1 check("mc_same_next", 32'(strb), 32'(S_IDLE));
        check("mc_same_stall", 32'(stall_cnt), 32'd6);

        // Timeout with MC_TIMEOUT = 8
        ex_mc_start = 1'b1;
        #1 check("to_start", 32'(strb), 32'(S_MC));
        cyc();
        ex_mc_start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            #1 check($sformatf("to_wait%0d", i), 32'(strb), 32'(S_MC));
            check($sformatf("to_err%0d", i), 32'(mc_error), 32'd0);
            cyc();
        end
        #1 check("to_abort", 32'(strb), 32'(S_TO));
        cyc();
        #1 check("to_err", 32'(mc_error), 32'd1);
        check("to_run", 32'(strb), 32'(S_IDLE));
        check("to_stall", 32'(stall_cnt), 32'd15);
        cyc();
        cyc();
        check("to_err_sticky", 32'(mc_error), 32'd1);

        // Single-step: 3 pulses, 10 cycles apart
        run = 1'b0;
        #1 check("step_idle", 32'(strb), 32'(S_NONE));
        pipe_hi = 0;
        pc_hi   = 0;
        for (int i = 0; i < 30; i++) begin
            step = (i % 10 == 0);
            #2;
            if (pipe_en) pipe_hi++;
            if (pc_en) pc_hi++;
            cyc();
        end
        step = 1'b0;
        check("step_pipe_hi", 32'(pipe_hi), 32'd3);
        check("step_pc_hi", 32'(pc_hi), 32'd3);

        // Held load-use in step mode: counters move only on pulses
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
        for (int i = 0; i < 30; i++) begin
            step = (i % 10 == 0);
            cyc();
        end
        step = 1'b0;
        #1 check("step_stall", 32'(stall_cnt), 32'd18);
        check("step_flush", 32'(flush_cnt), 32'd1);

        // Saturation with a continuously held stall
        run = 1'b1;
        repeat (70000) cyc();
        check("sat_stall", 32'(stall_cnt), 32'hFFFF);
        clear_inputs();

        // Reset in the middle of MC_WAIT, with a done that should be dropped
        ex_mc_start = 1'b1;
        cyc();
        ex_mc_start = 1'b0;
        cyc();
        #1 check("rst_mc_wait", 32'(strb), 32'(S_MC));
        reset = 1'b1;
        ex_mc_done = 1'b1;
        cyc();
        reset = 1'b0;
        ex_mc_done = 1'b0;
        #1 check("rst2_strobes", 32'(strb), 32'(S_IDLE));
        check("rst2_pc_en", 32'(pc_en), 32'd1);
        check("rst2_stall", 32'(stall_cnt), 32'd0);
        check("rst2_flush", 32'(flush_cnt), 32'd0);
        check("rst2_mcerr", 32'(mc_error), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
